des_round_engine: RTL and testbench

- Iterative DES datapath that sits directly downstream of the combinational key schedule and consumes its sixteen 48-bit subkeys.
- Applies the initial permutation, then 16 Feistel rounds (one per clock), then the final permutation, on one 64-bit block at a time.
- Supports encrypt and decrypt; decrypt uses the subkeys in reverse order.
- Provides valid/ready handshakes on input and output for integration into the top-level cipher wrapper.

---
 rtl/des_pkg.sv | 135 +++++++++++++
 rtl/des_f.sv | 25 ++
 rtl/des_round_engine.sv | 144 ++++++++++++++
 tb/tb_des_round_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants, permutation tables, S-boxes and bit-shuffling helpers.
// Throughout, vector bit (W-1) holds DES bit 1, so DES bit n lives at index W-n.
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef logic [47:0] subkey_t;
    typedef logic [31:0] half_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] blk);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[63-i] = blk[64-IP_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] blk);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[63-i] = blk[64-FP_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            res[47-i] = r[32-E_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] s);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            res[31-i] = s[32-P_TABLE[i]];
        end
        return res;
    endfunction

    // Outer bits {b1,b6} choose the row, inner bits b2..b5 the column.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] six);
        logic [5:0] idx;
        idx = {six[5], six[0], six[4:1]};
        return 4'(SBOX[box][idx]);
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): expand, key mix, S-box substitution, P permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mixed;
    logic [31:0] sboxOut;

    assign mixed = e_expand(r_i) ^ k_i;

    // Push each 6-bit slice of the mixed word through its own S-box.
    always_comb begin
        sboxOut = '0;
        for (int i = 0; i < 8; i++) begin
            sboxOut[31-4*i -: 4] = sbox_lookup(i, mixed[47-6*i -: 6]);
        end
    end

    assign f_o = p_perm(sboxOut);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: IP, sixteen Feistel rounds at one per clock, FP, with
// valid/ready on both sides. Subkeys come straight from the key schedule and
// are not latched, so upstream must keep them stable while busy is high.
module des_round_engine
    import des_pkg::*;
#(
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_decrypt,
    input  logic [47:0] subkey1,
    input  logic [47:0] subkey2,
    input  logic [47:0] subkey3,
    input  logic [47:0] subkey4,
    input  logic [47:0] subkey5,
    input  logic [47:0] subkey6,
    input  logic [47:0] subkey7,
    input  logic [47:0] subkey8,
    input  logic [47:0] subkey9,
    input  logic [47:0] subkey10,
    input  logic [47:0] subkey11,
    input  logic [47:0] subkey12,
    input  logic [47:0] subkey13,
    input  logic [47:0] subkey14,
    input  logic [47:0] subkey15,
    input  logic [47:0] subkey16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    half_t       l_q;
    half_t       r_q;
    logic        mode_q;
    logic [63:0] outData_q;
    logic        outValid_q;
    logic        busy_q;

    subkey_t     subkeys [DES_ROUNDS];
    subkey_t     roundKey;
    logic [3:0]  keyIdx;
    half_t       fOut;
    half_t       l_d;
    half_t       r_d;
    logic [63:0] ipBlock;
    logic [63:0] fpBlock;

    assign subkeys[0]  = subkey1;
    assign subkeys[1]  = subkey2;
    assign subkeys[2]  = subkey3;
    assign subkeys[3]  = subkey4;
    assign subkeys[4]  = subkey5;
    assign subkeys[5]  = subkey6;
    assign subkeys[6]  = subkey7;
    assign subkeys[7]  = subkey8;
    assign subkeys[8]  = subkey9;
    assign subkeys[9]  = subkey10;
    assign subkeys[10] = subkey11;
    assign subkeys[11] = subkey12;
    assign subkeys[12] = subkey13;
    assign subkeys[13] = subkey14;
    assign subkeys[14] = subkey15;
    assign subkeys[15] = subkey16;

    // Encrypt walks the key schedule forwards, decrypt walks it backwards.
    always_comb begin
        keyIdx   = mode_q ? (4'd15 - cnt_q) : cnt_q;
        roundKey = subkeys[keyIdx];
    end

    des_f uRoundF (
        .r_i (r_q),
        .k_i (roundKey),
        .f_o (fOut)
    );

    assign l_d     = r_q;
    assign r_d     = l_q ^ fOut;
    assign ipBlock = ip_perm(in_data);
    // Final round output is swapped back to {R16,L16} before FP.
    assign fpBlock = fp_perm({r_d, l_d});

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign busy      = busy_q;

    // Sequencer: accept a block, run the rounds, hold the result until popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            l_q        <= '0;
            r_q        <= '0;
            mode_q     <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ipBlock;
                        mode_q     <= in_decrypt;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(DES_ROUNDS - 1)) begin
                        outData_q  <= fpBlock;
                        outValid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                        if (CLEAR_ON_POP) begin
                            outData_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: the driver queues the expected result
// at each accept, and a monitor compares whenever the engine presents output.
`timescale 1ns/1ps
module tb_des_round_engine;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] CT2  = 64'h0000000000000000;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [63:0] data;
        int          acceptCycle;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [47:0] sk [16];

    logic [31:0] fR;
    logic [47:0] fK;
    logic [31:0] fProbe;

    exp_t expQ [$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    logic outValidPrev = 1'b0;

    des_round_engine #(.CLEAR_ON_POP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_decrypt (in_decrypt),
        .subkey1    (sk[0]),
        .subkey2    (sk[1]),
        .subkey3    (sk[2]),
        .subkey4    (sk[3]),
        .subkey5    (sk[4]),
        .subkey6    (sk[5]),
        .subkey7    (sk[6]),
        .subkey8    (sk[7]),
        .subkey9    (sk[8]),
        .subkey10   (sk[9]),
        .subkey11   (sk[10]),
        .subkey12   (sk[11]),
        .subkey13   (sk[12]),
        .subkey14   (sk[13]),
        .subkey15   (sk[14]),
        .subkey16   (sk[15]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    des_f uFProbe (
        .r_i (fR),
        .k_i (fK),
        .f_o (fProbe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Standard DES key schedule producing the sixteen subkeys.
    task automatic applyKey(input logic [63:0] key);
        logic [55:0] pc1Out;
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) pc1Out[55-i] = key[64-PC1[i]];
        c = pc1Out[55:28];
        d = pc1Out[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[r][47-i] = cd[56-PC2[i]];
        end
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic dec, input logic [63:0] expected,
                                 input string name, output int acc);
        exp_t e;
        bit   accepted;
        accepted = 0;
        acc      = -1;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        in_data    = data;
        in_decrypt = dec;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                acc           = cycle;
                e.data        = expected;
                e.acceptCycle = cycle;
                e.name        = name;
                expQ.push_back(e);
                accepted      = 1;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (!accepted) checkOutput({name, " accept timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while ((expQ.size() != 0 || busy) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) checkOutput("drain timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: latency on the rising edge of out_valid, data every valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !outValidPrev) begin
                if (expQ.size() == 0)
                    checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
                else
                    checkOutput({expQ[0].name, " latency"}, 64'(cycle - expQ[0].acceptCycle), 64'd16);
            end
            if (out_valid && expQ.size() > 0) begin
                checkOutput({expQ[0].name, " data"}, out_data, expQ[0].data);
                if (out_ready) void'(expQ.pop_front());
            end
        end
        outValidPrev = out_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, acc1, acc2, acc3, k;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b1;
        fR         = '0;
        fK         = '0;
        applyKey(KEY1);
        #12;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset out_data", out_data, 64'd0);

        fR = 32'hF0AAF0AA;
        fK = sk[0];
        #1;
        checkOutput("f round1", 64'(fProbe), 64'h234AA9BB);

        @(negedge clk);
        rst = 1'b0;

        $display("[TB] encrypt / decrypt, key1");
        applyStimulus(PT1, 1'b0, CT1, "enc1", acc);
        waitDrain();
        applyStimulus(CT1, 1'b1, PT1, "dec1", acc);
        waitDrain();

        $display("[TB] encrypt / decrypt, key2");
        applyKey(KEY2);
        applyStimulus(PT2, 1'b0, CT2, "enc2", acc);
        waitDrain();
        applyStimulus(CT2, 1'b1, PT2, "dec2", acc);
        waitDrain();
        applyKey(KEY1);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(PT1, 1'b0, CT1, "bp", acc);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("bp out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp in_ready at pop", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("bp in_ready after pop", 64'(in_ready), 64'd1);
        checkOutput("bp out_data cleared", out_data, 64'd0);
        checkOutput("bp out_valid after pop", 64'(out_valid), 64'd0);
        checkOutput("bp busy after pop", 64'(busy), 64'd0);
        waitDrain();

        $display("[TB] busy ignore");
        applyStimulus(PT1, 1'b0, CT1, "busyign", acc);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 64'hFFFFFFFFFFFFFFFF;
            @(negedge clk);
            checkOutput("busyign in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_data  = '0;
        waitDrain();
        repeat (20) @(negedge clk);

        $display("[TB] reset mid-run");
        applyStimulus(PT1, 1'b0, CT1, "rstmid", acc);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("rstmid out_valid", 64'(out_valid), 64'd0);
        checkOutput("rstmid out_data", out_data, 64'd0);
        checkOutput("rstmid in_ready", 64'(in_ready), 64'd1);
        checkOutput("rstmid busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(PT1, 1'b0, CT1, "afterrst", acc);
        waitDrain();

        $display("[TB] back-to-back");
        applyStimulus(PT1, 1'b0, CT1, "b2b1", acc1);
        applyStimulus(CT1, 1'b1, PT1, "b2b2", acc2);
        applyStimulus(PT1, 1'b0, CT1, "b2b3", acc3);
        checkOutput("b2b gap 1-2", 64'(acc2 - acc1), 64'd18);
        checkOutput("b2b gap 2-3", 64'(acc3 - acc2), 64'd18);
        waitDrain();
        repeat (4) @(negedge clk);
        checkOutput("queue empty at end", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
